relu_stream: RTL and testbench
==============================

Name: relu_stream

Overview:
- Multi-lane streaming activation unit for the LeNet/VGG16 datapath.
- Sits between the conv/accumulator output stage and the pooling stage.
- Applies a per-frame selectable activation to LANES signed fixed-point elements per beat, using a valid/ready handshake.
- Reports a per-frame count of elements zeroed by the activation, for sparsity monitoring.

Parameters:
- DATA_SIZE, 8: element width in bits, two's complement.
- LANES, 4: elements per beat.
- LEAK_SHIFT, 3: arithmetic right-shift amount for leaky mode.
- CNT_W, 16: width of the zero-count statistic.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  activation select: 0 pass, 1 ReLU, 2 leaky ReLU, 3 clipped ReLU.
- clip_val  in  DATA_SIZE  signed upper bound for mode 3.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  LANES*DATA_SIZE  lane i at bits [i*DATA_SIZE +: DATA_SIZE].
- in_last  in  1  final beat of frame.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*DATA_SIZE  activated lanes, same packing.
- out_last  out  1  final beat of frame.
- zero_cnt  out  CNT_W  zeroed-element total of the last completed frame.
- frame_done  out  1  one-cycle pulse when a frame's last beat leaves.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, zero_cnt=0, frame_done=0. Skid register empty, running counter 0, frame-start flag set.
- Reset mid-frame: the frame is discarded; no partial zero_cnt or frame_done is produced.
- Handshake: a beat transfers when valid&&ready on a rising edge. in_valid, once high, stays high until accepted. Data is stable while out_valid && !out_ready.
- Pipeline: output register plus one-entry skid register. Latency is 1 cycle from input acceptance to out_valid. Throughput is 1 beat/cycle while out_ready=1.
- in_ready is a flop output with no combinational path from out_ready. in_ready = skid empty.
- Skid fill: if the output register is full, out_ready=0, and a beat is accepted, the beat goes to the skid register and in_ready drops next cycle.
- Skid drain: when the output register is consumed, the skid contents move into it and in_ready rises next cycle.
- Skid empty: with the output register empty or being consumed, an accepted beat loads the output register directly.
- Mode and clip_val sampling: sampled on the first accepted beat of each frame (after reset or after an in_last beat). They are held internally for the rest of the frame; mid-frame port changes are ignored.
- Per-lane function, x signed:
  - mode 0: y=x.
  - mode 1: y = x<0 ? 0 : x.
  - mode 2: y = x<0 ? x>>>LEAK_SHIFT : x. Arithmetic shift, so -1 stays -1.
  - mode 3: y = x<0 ? 0 : (x>clip_val ? clip_val : x). If clip_val<0, y=0 for all x.
- Zero counting: per output beat, the count is the number of lanes forced to 0 from a negative x (modes 1 and 3 only). Clip-to-zero from a negative clip_val also counts.
- Counter update: the running counter accumulates on output handshakes only and saturates at 2^CNT_W-1.
- Frame close: on an output handshake with out_last=1, zero_cnt <= running + this beat's count (saturating), frame_done pulses 1 cycle, and the running counter clears. A new frame's first beat may be accepted the same cycle.
- Single-beat frame (first beat with in_last=1) is legal: mode is sampled and the frame closes on the same beat.
- out_last travels with its data through the skid path.

Decomposition:
- Shared package relu_pkg: DATA_SIZE default, mode encodings MODE_PASS/MODE_RELU/MODE_LEAKY/MODE_CLIP, lane slice helper function.
- Sub-module relu_lane: combinational single-element activation. Outputs y and a zeroed flag. Instantiated LANES times via generate.
- relu_stream holds the skid/handshake logic and the counter.

Test Plan:
- Reset, then mode=1, LANES=4 beat {-5,3,-128,127}, out_ready=1 → next cycle out_data {0,3,0,127}. With in_last=1: frame_done=1, zero_cnt=2.
- mode=2, lanes {-16,-1,8,-128} → {-2,-1,8,-16}. zero_cnt=0 at frame end.
- mode=3, clip_val=6, lanes {10,6,-3,2} → {6,6,0,2}. Then clip_val=-4 → all zero, count 4.
- 8-beat frame, mode changed to 0 at beat 3 → all 8 beats use the mode sampled at beat 0. zero_cnt is the full-frame total.
- out_ready held 0 for 5 cycles with in_valid=1 → exactly 2 beats accepted, in_ready=0 from cycle 2. On release, beats emerge in order with no loss or duplication.
- Random valid/ready over 1000 beats, CNT_W=4, all-negative mode 1 → scoreboard matches; zero_cnt saturates at 15. rst_n pulsed mid-frame → outputs return to reset values immediately.

Source files
------------

// File: rtl/relu_pkg.sv
// Shared mode encodings, default element width and lane-slicing helper
// for the relu_stream activation datapath.
package relu_pkg;

  localparam int DATA_SIZE = 8;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_RELU  = 2'd1,
    MODE_LEAKY = 2'd2,
    MODE_CLIP  = 2'd3
  } mode_e;

  // LSB position of a lane inside a packed multi-lane bus.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/relu_lane.sv
// Single-element activation, purely combinational (0 cycles, no handshake).
// zeroed_o flags lanes forced to 0 by a negative input or a negative clip bound.
module relu_lane import relu_pkg::*; #(
  parameter int DATA_SIZE  = relu_pkg::DATA_SIZE,
  parameter int LEAK_SHIFT = 3
) (
  input  mode_e                       mode_i,
  input  logic signed [DATA_SIZE-1:0] clip_i,
  input  logic signed [DATA_SIZE-1:0] x_i,
  output logic signed [DATA_SIZE-1:0] y_o,
  output logic                        zeroed_o
);

  logic x_neg;
  logic clip_neg;

  assign x_neg    = x_i[DATA_SIZE-1];
  assign clip_neg = clip_i[DATA_SIZE-1];

  always_comb begin
    y_o      = x_i;
    zeroed_o = 1'b0;
    case (mode_i)
      MODE_RELU: begin
        if (x_neg) begin
          y_o      = '0;
          zeroed_o = 1'b1;
        end
      end
      MODE_LEAKY: begin
        if (x_neg) y_o = x_i >>> LEAK_SHIFT;
      end
      MODE_CLIP: begin
        // A negative bound leaves no legal non-negative output, so every lane collapses to 0.
        if (x_neg || clip_neg) begin
          y_o      = '0;
          zeroed_o = 1'b1;
        end else if (x_i > clip_i) begin
          y_o = clip_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/relu_stream.sv
// LANES-wide streaming activation with per-frame zero count; 1-cycle latency, 1 beat/cycle.
// Backpressure absorbed by a one-entry skid register; in_ready is registered (skid empty).
module relu_stream import relu_pkg::*; #(
  parameter int DATA_SIZE  = relu_pkg::DATA_SIZE,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 mode,
  input  logic [DATA_SIZE-1:0]       clip_val,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*DATA_SIZE-1:0] in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*DATA_SIZE-1:0] out_data,
  output logic                       out_last,
  output logic [CNT_W-1:0]           zero_cnt,
  output logic                       frame_done
);

  localparam int BW    = $clog2(LANES + 1);
  localparam int BUS_W = LANES * DATA_SIZE;

  mode_e                mode_q;
  logic [DATA_SIZE-1:0] clip_q;
  logic                 first_q;
  mode_e                mode_eff;
  logic [DATA_SIZE-1:0] clip_eff;

  logic [BUS_W-1:0] act_dat;
  logic [LANES-1:0] act_zero;
  logic [BW-1:0]    act_cnt;

  logic             out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic [BUS_W-1:0] out_dat_q, out_dat_d;
  logic [BW-1:0]    out_cnt_q, out_cnt_d;
  logic             skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
  logic [BUS_W-1:0] skid_dat_q, skid_dat_d;
  logic [BW-1:0]    skid_cnt_q, skid_cnt_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d, zero_cnt_q, zero_cnt_d;
  logic             frame_done_q, frame_done_d;

  logic             in_fire, out_fire;
  logic [CNT_W:0]   sum_w;
  logic [CNT_W-1:0] sum_sat;

  // The first beat of a frame uses the live port values; later beats use the held copy.
  assign mode_eff = first_q ? mode_e'(mode) : mode_q;
  assign clip_eff = first_q ? clip_val : clip_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    relu_lane #(
      .DATA_SIZE  (DATA_SIZE),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .mode_i   (mode_eff),
      .clip_i   (clip_eff),
      .x_i      (in_data[lane_lsb(i, DATA_SIZE) +: DATA_SIZE]),
      .y_o      (act_dat[lane_lsb(i, DATA_SIZE) +: DATA_SIZE]),
      .zeroed_o (act_zero[i])
    );
  end

  always_comb begin
    act_cnt = '0;
    for (int i = 0; i < LANES; i++) act_cnt = act_cnt + BW'(act_zero[i]);
  end

  assign in_ready = ~skid_vld_q;
  assign in_fire  = in_valid & ~skid_vld_q;
  assign out_fire = out_vld_q & out_ready;
  assign sum_w    = {1'b0, run_cnt_q} + (CNT_W+1)'(out_cnt_q);
  assign sum_sat  = sum_w[CNT_W] ? '1 : sum_w[CNT_W-1:0];

  always_comb begin
    out_vld_d    = out_vld_q;
    out_dat_d    = out_dat_q;
    out_last_d   = out_last_q;
    out_cnt_d    = out_cnt_q;
    skid_vld_d   = skid_vld_q;
    skid_dat_d   = skid_dat_q;
    skid_last_d  = skid_last_q;
    skid_cnt_d   = skid_cnt_q;
    run_cnt_d    = run_cnt_q;
    zero_cnt_d   = zero_cnt_q;
    frame_done_d = 1'b0;

    if (out_fire || !out_vld_q) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_dat_d  = skid_dat_q;
        out_last_d = skid_last_q;
        out_cnt_d  = skid_cnt_q;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = in_fire;
        if (in_fire) begin
          out_dat_d  = act_dat;
          out_last_d = in_last;
          out_cnt_d  = act_cnt;
        end
      end
    end else if (in_fire) begin
      skid_vld_d  = 1'b1;
      skid_dat_d  = act_dat;
      skid_last_d = in_last;
      skid_cnt_d  = act_cnt;
    end

    if (out_fire) begin
      if (out_last_q) begin
        zero_cnt_d   = sum_sat;
        run_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        run_cnt_d = sum_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q    <= 1'b0;
      out_dat_q    <= '0;
      out_last_q   <= 1'b0;
      out_cnt_q    <= '0;
      skid_vld_q   <= 1'b0;
      skid_dat_q   <= '0;
      skid_last_q  <= 1'b0;
      skid_cnt_q   <= '0;
      run_cnt_q    <= '0;
      zero_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      first_q      <= 1'b1;
      mode_q       <= MODE_PASS;
      clip_q       <= '0;
    end else begin
      out_vld_q    <= out_vld_d;
      out_dat_q    <= out_dat_d;
      out_last_q   <= out_last_d;
      out_cnt_q    <= out_cnt_d;
      skid_vld_q   <= skid_vld_d;
      skid_dat_q   <= skid_dat_d;
      skid_last_q  <= skid_last_d;
      skid_cnt_q   <= skid_cnt_d;
      run_cnt_q    <= run_cnt_d;
      zero_cnt_q   <= zero_cnt_d;
      frame_done_q <= frame_done_d;
      if (in_fire) begin
        first_q <= in_last;
        if (first_q) begin
          mode_q <= mode_e'(mode);
          clip_q <= clip_val;
        end
      end
    end
  end

  assign out_valid  = out_vld_q;
  assign out_data   = out_dat_q;
  assign out_last   = out_last_q;
  assign zero_cnt   = zero_cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_stream.sv
// Directed bench for relu_stream: hand-computed beats and frame counts in queues,
// popped by a negedge monitor on every output handshake and frame_done pulse.
module tb_relu_stream;

  localparam int DW = 8;
  localparam int LN = 4;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       mode;
  logic [DW-1:0]    clip_val;
  logic             in_valid;
  logic             in_ready;
  logic [LN*DW-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [LN*DW-1:0] out_data;
  logic             out_last;
  logic [CW-1:0]    zero_cnt;
  logic             frame_done;

  always #5 clk = ~clk;

  relu_stream #(
    .DATA_SIZE  (DW),
    .LANES      (LN),
    .LEAK_SHIFT (3),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .clip_val   (clip_val),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .zero_cnt   (zero_cnt),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt  = 0;

  logic [LN*DW:0] exp_q[$];
  logic [CW-1:0]  exp_cnt_q[$];
  logic [LN*DW:0] e_beat;
  logic [CW-1:0]  e_cnt;
  logic           sender_done;
  logic           rnd_en;
  logic           rnd_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LN*DW-1:0] pk(input int a, input int b, input int c, input int d);
    logic [DW-1:0] l0, l1, l2, l3;
    l0 = a[DW-1:0];
    l1 = b[DW-1:0];
    l2 = c[DW-1:0];
    l3 = d[DW-1:0];
    return {l3, l2, l1, l0};
  endfunction

  task automatic expect_beat(input logic [LN*DW-1:0] d, input logic last);
    exp_q.push_back({d, last});
  endtask

  task automatic send(input logic [LN*DW-1:0] d, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        check("in_ready_timeout", in_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || exp_cnt_q.size() != 0) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    if (t >= 5000) check(tag, exp_q.size() + exp_cnt_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", out_valid, 0);
        end else begin
          e_beat = exp_q.pop_front();
          check("out_data", out_data, e_beat[LN*DW:1]);
          check("out_last", out_last, e_beat[0]);
        end
      end
      if (frame_done) begin
        if (exp_cnt_q.size() == 0) begin
          check("unexpected_frame_done", frame_done, 0);
        end else begin
          e_cnt = exp_cnt_q.pop_front();
          check("zero_cnt", zero_cnt, e_cnt);
        end
      end
      if (in_valid && in_ready) acc_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc0;
    int beats;
    int len;
    logic [CW-1:0] c;

    rst_n = 1'b0; mode = 2'd0; clip_val = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    sender_done = 1'b0; rnd_en = 1'b0; rnd_done = 1'b0;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_zero_cnt", zero_cnt, 0);
    check("rst_frame_done", frame_done, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ReLU single-beat frame
    mode = 2'd1;
    expect_beat(pk(0, 3, 0, 127), 1'b1); exp_cnt_q.push_back(4'd2);
    send(pk(-5, 3, -128, 127), 1'b1);
    check("latency_out_valid", out_valid, 1);
    wait_drain("drain_relu");

    // Leaky: arithmetic shift keeps -1 at -1
    mode = 2'd2;
    expect_beat(pk(-2, -1, 8, -16), 1'b1); exp_cnt_q.push_back(4'd0);
    send(pk(-16, -1, 8, -128), 1'b1);
    wait_drain("drain_leaky");

    // Clip with positive then negative bound
    mode = 2'd3; clip_val = 8'd6;
    expect_beat(pk(6, 6, 0, 2), 1'b1); exp_cnt_q.push_back(4'd1);
    send(pk(10, 6, -3, 2), 1'b1);
    clip_val = 8'hFC;
    expect_beat(pk(0, 0, 0, 0), 1'b1); exp_cnt_q.push_back(4'd4);
    send(pk(10, 6, -3, 2), 1'b1);
    wait_drain("drain_clip");

    // Pass-through
    mode = 2'd0;
    expect_beat(pk(-7, 0, 7, -128), 1'b1); exp_cnt_q.push_back(4'd0);
    send(pk(-7, 0, 7, -128), 1'b1);
    wait_drain("drain_pass");

    // 8-beat frame; mid-frame mode/clip changes must be ignored
    mode = 2'd1;
    for (int k = 0; k < 8; k++) expect_beat(pk(0, k, 3, 127), k == 7);
    exp_cnt_q.push_back(4'd8);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin mode = 2'd0; clip_val = 8'd1; end
      send(pk(-(k + 1), k, 3, 127), k == 7);
    end
    wait_drain("drain_hold");

    // Backpressure: 5 stalled cycles admit exactly two beats
    mode = 2'd1;
    for (int k = 0; k < 4; k++) expect_beat(pk(k + 1, 0, 10 * k, 0), k == 3);
    exp_cnt_q.push_back(4'd8);
    out_ready = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        for (int k = 0; k < 4; k++) send(pk(k + 1, -(k + 1), 10 * k, -100), k == 3);
        sender_done = 1'b1;
      end
    join_none
    repeat (2) @(posedge clk); #1;
    check("stall_in_ready_c2", in_ready, 0);
    repeat (3) @(posedge clk); #1;
    check("stall_accepted", acc_cnt - acc0, 2);
    check("stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int t = 0; t < 100 && !sender_done; t++) @(posedge clk);
    #1;
    check("stall_sender_done", sender_done, 1);
    wait_drain("drain_stall");

    // Random valid/ready, all-negative ReLU, counter saturates at 15
    mode = 2'd1;
    rnd_en = 1'b1;
    fork
      begin
        while (rnd_en) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
        rnd_done = 1'b1;
      end
    join_none
    beats = 0;
    while (beats < 1000) begin
      len = (beats == 0) ? 8 : $urandom_range(1, 8);
      if (beats + len > 1000) len = 1000 - beats;
      for (int k = 0; k < len; k++) expect_beat('0, k == len - 1);
      c = (4 * len > 15) ? 4'd15 : CW'(4 * len);
      exp_cnt_q.push_back(c);
      for (int k = 0; k < len; k++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send(pk(-int'($urandom_range(1, 128)), -int'($urandom_range(1, 128)),
                -int'($urandom_range(1, 128)), -int'($urandom_range(1, 128))), k == len - 1);
      end
      beats += len;
    end
    rnd_en = 1'b0;
    for (int t = 0; t < 10 && !rnd_done; t++) @(posedge clk);
    #1;
    wait_drain("drain_random");

    // Mid-frame reset discards the frame and re-arms mode sampling
    mode = 2'd1;
    out_ready = 1'b0;
    send(pk(-1, -2, -3, -4), 1'b0);
    send(pk(-1, -2, -3, -4), 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_data", out_data, 0);
    check("midrst_zero_cnt", zero_cnt, 0);
    check("midrst_frame_done", frame_done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    mode = 2'd2;
    expect_beat(pk(-1, 1, 1, 1), 1'b1); exp_cnt_q.push_back(4'd0);
    send(pk(-8, 1, 1, 1), 1'b1);
    wait_drain("drain_post_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
